// File: rtl/systolic_link_pkg.sv
// Shared definitions for the narrow systolic result link.
// Used by result_transmitter today and intended for the future link receiver.
//   SYNC_WORD      : marker byte carried in the upper half of every header beat
//   LINK_WIDTH     : width of one link beat
//   BEATS_PER_WORD : data beats that follow each header
//   tx_state_e     : transmitter framing states
package systolic_link_pkg;

  localparam logic [7:0] SYNC_WORD      = 8'hA5;
  localparam int         LINK_WIDTH     = 16;
  localparam int         BEATS_PER_WORD = 4;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_HEADER = 2'd1,
    TX_DATA   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/result_fifo.sv
// Single-clock result buffer, DEPTH words of DATA_WIDTH bits.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (flushes pointers/count)
//   push, push_data   : write request and word; ignored while full
//   pop               : remove the head word; ignored while empty
//   head_data         : word at the head (valid while !empty)
//   count             : occupancy 0..DEPTH
//   full, empty       : decoded from count
module result_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic                  push_ok;
  logic                  pop_ok;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[head];

  // Storage is not reset; a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= push_data;
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_transmitter.sv
// Buffers 64-bit result words and frames each one onto the 16-bit external
// link as a header beat {SYNC_WORD, seq} followed by four data beats, LSB first.
// Ports:
//   external_clk, rst : clock, synchronous active-high reset
//   result_in/_valid  : upstream word and valid; result_ready = FIFO not full
//   tx_data/_valid    : link beat, held until accepted by tx_ready
//   tx_last           : marks the final data beat of a packet
//   buffer_empty      : FIFO holds no words
//   level             : FIFO occupancy 0..DEPTH
//
// state     | meaning
// TX_IDLE   | nothing on the link; pop and present a header when a word is queued
// TX_HEADER | header beat presented, waiting for tx_ready
// TX_DATA   | data beat beat_idx presented, waiting for tx_ready
module result_transmitter
  import systolic_link_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         ADDR_WIDTH = 4,
  parameter logic [7:0] SYNC_WORD  = systolic_link_pkg::SYNC_WORD
) (
  input  logic                  external_clk,
  input  logic                  rst,
  input  logic [63:0]           result_in,
  input  logic                  result_valid,
  output logic                  result_ready,
  output logic [LINK_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  buffer_empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam logic [1:0] LAST_IDX = 2'(BEATS_PER_WORD - 1);

  tx_state_e   state;
  logic [63:0] shift_reg;
  logic [1:0]  beat_idx;
  logic [7:0]  seq;
  logic [63:0] head_data;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;

  result_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (64)
  ) u_fifo (
    .clk       (external_clk),
    .rst       (rst),
    .push      (result_valid),
    .push_data (result_in),
    .pop       (pop),
    .head_data (head_data),
    .count     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign result_ready = !fifo_full;
  assign buffer_empty = fifo_empty;

  // Pop when a header is about to be loaded: from idle, or straight after the
  // last data beat is accepted so back-to-back packets have no bubble.
  always_comb begin
    pop = 1'b0;
    case (state)
      TX_IDLE: pop = !fifo_empty;
      TX_DATA: pop = tx_ready && (beat_idx == LAST_IDX) && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge external_clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      shift_reg <= '0;
      beat_idx  <= '0;
      seq       <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            shift_reg <= head_data;
            tx_data   <= {SYNC_WORD, seq};
            tx_valid  <= 1'b1;
            tx_last   <= 1'b0;
            state     <= TX_HEADER;
          end
        end
        TX_HEADER: begin
          if (tx_ready) begin
            tx_data   <= shift_reg[LINK_WIDTH-1:0];
            shift_reg <= shift_reg >> LINK_WIDTH;
            beat_idx  <= '0;
            state     <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_ready) begin
            if (beat_idx == LAST_IDX) begin
              seq     <= seq + 8'd1;
              tx_last <= 1'b0;
              if (!fifo_empty) begin
                shift_reg <= head_data;
                tx_data   <= {SYNC_WORD, seq + 8'd1};
                state     <= TX_HEADER;
              end else begin
                tx_valid <= 1'b0;
                state    <= TX_IDLE;
              end
            end else begin
              tx_data   <= shift_reg[LINK_WIDTH-1:0];
              shift_reg <= shift_reg >> LINK_WIDTH;
              beat_idx  <= beat_idx + 2'd1;
              tx_last   <= ((beat_idx + 2'd1) == LAST_IDX);
            end
          end
        end
        default: begin
          state    <= TX_IDLE;
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_transmitter.sv
module tb_result_transmitter;

  logic        external_clk = 1'b0;
  logic        rst          = 1'b1;
  logic [63:0] result_in    = '0;
  logic        result_valid = 1'b0;
  logic        result_ready;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready     = 1'b0;
  logic        buffer_empty;
  logic [4:0]  level;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  result_transmitter #(
    .DEPTH      (16),
    .ADDR_WIDTH (4),
    .SYNC_WORD  (8'hA5)
  ) dut (
    .external_clk (external_clk),
    .rst          (rst),
    .result_in    (result_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .buffer_empty (buffer_empty),
    .level        (level)
  );

  always #5 external_clk = ~external_clk;

  task automatic step();
    @(posedge external_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int i);
    return 64'h1000_2000_3000_4000 + 64'(i) * 64'h0001_0001_0001_0001;
  endfunction

  task automatic push_word(input logic [63:0] w);
    result_in    = w;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    result_valid = 1'b0;
    tx_ready     = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Waits (bounded) for the next accepted beat; while a beat is stalled it
  // must stay unchanged across the edge.
  task automatic next_beat(input bit stall, output logic [15:0] d, output logic l, output int c);
    logic [15:0] hd;
    logic        hl, hv, hr;
    bit          got;
    got = 1'b0;
    d   = 'x;
    l   = 1'bx;
    c   = -1;
    for (int n = 0; n < 300 && !got; n++) begin
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hv = tx_valid;
      hr = tx_ready;
      hd = tx_data;
      hl = tx_last;
      if (hv && hr) begin
        d   = hd;
        l   = hl;
        c   = cyc;
        got = 1'b1;
      end
      step();
      if (hv && !hr) begin
        chk("hold_valid", 64'(tx_valid), 64'd1);
        chk("hold_data",  64'(tx_data),  64'(hd));
        chk("hold_last",  64'(tx_last),  64'(hl));
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $error("FAIL beat_timeout: observed no beat expected a beat");
    end
  endtask

  task automatic recv_packet(input logic [63:0] w, input logic [7:0] s, input bit stall,
                             output int c0, output int c4);
    logic [15:0] d;
    logic        l;
    int          c;
    next_beat(stall, d, l, c);
    c0 = c;
    chk("hdr",      64'(d), 64'({8'hA5, s}));
    chk("hdr_last", 64'(l), 64'd0);
    for (int b = 0; b < 4; b++) begin
      next_beat(stall, d, l, c);
      chk("data_beat", 64'(d), 64'(w[16*b +: 16]));
      chk("data_last", 64'(l), (b == 3) ? 64'd1 : 64'd0);
    end
    c4 = c;
  endtask

  initial begin
    int c0, c4, cfirst;
    logic [63:0] wa, wb, wc;

    // Reset values
    do_reset();
    chk("rst_tx_valid",     64'(tx_valid),     64'd0);
    chk("rst_tx_last",      64'(tx_last),      64'd0);
    chk("rst_tx_data",      64'(tx_data),      64'd0);
    chk("rst_buffer_empty", 64'(buffer_empty), 64'd1);
    chk("rst_level",        64'(level),        64'd0);
    chk("rst_result_ready", 64'(result_ready), 64'd1);

    // Single word, tx_ready high: exact per-edge latency
    tx_ready = 1'b1;
    push_word(64'h1122_3344_5566_7788);
    chk("e0_valid", 64'(tx_valid), 64'd0);
    chk("e0_level", 64'(level),    64'd1);
    chk("e0_empty", 64'(buffer_empty), 64'd0);
    step();
    chk("e1_valid", 64'(tx_valid), 64'd1);
    chk("e1_data",  64'(tx_data),  64'h0000_0000_0000_A500);
    chk("e1_last",  64'(tx_last),  64'd0);
    chk("e1_level", 64'(level),    64'd0);
    step();
    chk("e2_data",  64'(tx_data),  64'h7788);
    chk("e2_last",  64'(tx_last),  64'd0);
    step();
    chk("e3_data",  64'(tx_data),  64'h5566);
    chk("e3_last",  64'(tx_last),  64'd0);
    step();
    chk("e4_data",  64'(tx_data),  64'h3344);
    chk("e4_last",  64'(tx_last),  64'd0);
    step();
    chk("e5_data",  64'(tx_data),  64'h1122);
    chk("e5_last",  64'(tx_last),  64'd1);
    chk("e5_valid", 64'(tx_valid), 64'd1);
    step();
    chk("e6_valid", 64'(tx_valid), 64'd0);
    chk("e6_last",  64'(tx_last),  64'd0);
    chk("e6_empty", 64'(buffer_empty), 64'd1);

    // Three words back-to-back: 15 contiguous beats once the link opens
    do_reset();
    push_word(mk(0));
    push_word(mk(1));
    push_word(mk(2));
    chk("b2b_level", 64'(level), 64'd2);
    recv_packet(mk(0), 8'h00, 1'b0, c0, c4);
    cfirst = c0;
    recv_packet(mk(1), 8'h01, 1'b0, c0, c4);
    recv_packet(mk(2), 8'h02, 1'b0, c0, c4);
    chk("b2b_span", 64'(c4 - cfirst), 64'd14);
    chk("b2b_idle", 64'(tx_valid), 64'd0);

    // Same three words under random stalls
    do_reset();
    push_word(mk(0));
    push_word(mk(1));
    push_word(mk(2));
    recv_packet(mk(0), 8'h00, 1'b1, c0, c4);
    recv_packet(mk(1), 8'h01, 1'b1, c0, c4);
    recv_packet(mk(2), 8'h02, 1'b1, c0, c4);
    tx_ready = 1'b1;
    step();
    chk("stall_idle", 64'(tx_valid), 64'd0);

    // Fill: word 0 sits in the stalled header, 16 more fill the FIFO
    do_reset();
    for (int i = 0; i < 17; i++) push_word(mk(i));
    chk("full_level", 64'(level),        64'd16);
    chk("full_ready", 64'(result_ready), 64'd0);
    chk("full_empty", 64'(buffer_empty), 64'd0);
    result_in    = 64'hDEAD_BEEF_DEAD_BEEF;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    chk("full_drop_level", 64'(level), 64'd16);
    recv_packet(mk(0), 8'h00, 1'b0, c0, c4);
    chk("first_pop_ready", 64'(result_ready), 64'd1);
    chk("first_pop_level", 64'(level),        64'd15);
    for (int i = 1; i < 17; i++) recv_packet(mk(i), 8'(i), 1'b0, c0, c4);
    chk("drain_valid", 64'(tx_valid),     64'd0);
    chk("drain_empty", 64'(buffer_empty), 64'd1);

    // Sequence number wraps 255 -> 0 on packet 256
    do_reset();
    for (int k = 0; k < 257; k++) begin
      push_word(mk(k));
      recv_packet(mk(k), 8'(k), 1'b0, c0, c4);
    end

    // Reset during data beat 2 abandons the packet and flushes the FIFO
    do_reset();
    wa = 64'hAAAA_BBBB_CCCC_DDDD;
    wb = 64'h0123_4567_89AB_CDEF;
    wc = 64'hFEDC_BA98_7654_3210;
    push_word(wa);
    push_word(wb);
    tx_ready = 1'b1;
    step();
    step();
    step();
    chk("mid_beat2", 64'(tx_data), 64'hBBBB);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(tx_valid),     64'd0);
    chk("mid_rst_level", 64'(level),        64'd0);
    chk("mid_rst_empty", 64'(buffer_empty), 64'd1);
    chk("mid_rst_last",  64'(tx_last),      64'd0);
    push_word(wc);
    recv_packet(wc, 8'h00, 1'b0, c0, c4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
